// File: rtl/huffman_shift_reg.sv
// Serial Huffman decoder front end: takes 1-4 bit chunks, shifts them MSB-first into a
// code buffer one bit per cycle, and pulses tvalid with the signed symbol on each codeword hit.

module huffman_shift_reg_fsm (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  input  logic last_bit,
  output logic shift_en
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;

  // shift_en is registered alongside the state so it equals (state == SHIFT) with no decode path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shift_en <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state    <= SHIFT;
          shift_en <= 1'b1;
        end
        SHIFT: if (last_bit) begin
          state    <= IDLE;
          shift_en <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          shift_en <= 1'b0;
        end
      endcase
    end
  end
endmodule

module huffman_shift_reg #(
  parameter int MAX_CODE = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sValid,
  input  logic [3:0]        in_bits,
  input  logic [2:0]        in_len,
  output logic signed [3:0] decodedData,
  output logic              tvalid
);
  logic                sv_d;
  logic [MAX_CODE-1:0] shift_buf;
  logic [3:0]          bit_count;
  logic [3:0]          pend_bits;
  logic [2:0]          pend_cnt;
  logic                shift_en;
  logic                accept;
  logic                last_bit;
  logic [1:0]          nb_idx;
  logic                nb;
  logic [MAX_CODE-1:0] cand;
  logic [3:0]          clen;
  logic                hit;
  logic signed [3:0]   sym;

  // shift_en low is exactly the FSM IDLE state, so it gates acceptance of new chunks.
  assign accept   = sValid && !sv_d && !shift_en && (in_len != 3'd0);
  assign last_bit = (pend_cnt == 3'd1);
  assign nb_idx   = 2'(pend_cnt - 3'd1);
  assign nb       = pend_bits[nb_idx];
  // The buffer's top bit is always 0 here (a full-length candidate is always consumed).
  assign cand     = MAX_CODE'({shift_buf, nb});
  assign clen     = bit_count + 4'd1;

  huffman_shift_reg_fsm u_fsm (
    .clk      (clk),
    .reset    (reset),
    .accept   (accept),
    .last_bit (last_bit),
    .shift_en (shift_en)
  );

  // Exact-length match; bits of cand above clen are always zero because the buffer is
  // cleared on every hit or invalid code.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    sym = 4'sd0;
    case (clen)
      4'd2: if (cand[1:0] == 2'b00) begin hit = 1'b1; sym = 4'sd0; end
      4'd3: begin
        case (cand[2:0])
          3'b010:  begin hit = 1'b1; sym =  4'sd1; end
          3'b011:  begin hit = 1'b1; sym = -4'sd1; end
          3'b100:  begin hit = 1'b1; sym =  4'sd2; end
          3'b101:  begin hit = 1'b1; sym = -4'sd2; end
          default: ;
        endcase
      end
      4'd4: if (cand[3:1] == 3'b110)     begin hit = 1'b1; sym = cand[0] ? -4'sd3 : 4'sd3; end
      4'd5: if (cand[4:1] == 4'b1110)    begin hit = 1'b1; sym = cand[0] ? -4'sd4 : 4'sd4; end
      4'd6: if (cand[5:1] == 5'b11110)   begin hit = 1'b1; sym = cand[0] ? -4'sd5 : 4'sd5; end
      4'd7: if (cand[6:1] == 6'b111110)  begin hit = 1'b1; sym = cand[0] ? -4'sd6 : 4'sd6; end
      4'd8: if (cand[7:1] == 7'b1111110) begin hit = 1'b1; sym = cand[0] ? -4'sd7 : 4'sd7; end
      4'd9: if (cand[8:0] == 9'b111111100) begin hit = 1'b1; sym = -4'sd8; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sv_d        <= 1'b0;
      shift_buf   <= '0;
      bit_count   <= 4'd0;
      pend_bits   <= 4'd0;
      pend_cnt    <= 3'd0;
      decodedData <= 4'sd0;
      tvalid      <= 1'b0;
    end else begin
      sv_d   <= sValid;
      tvalid <= 1'b0;
      if (accept) begin
        pend_bits <= in_bits;
        pend_cnt  <= in_len;
      end else if (shift_en) begin
        pend_cnt <= pend_cnt - 3'd1;
        if (hit) begin
          decodedData <= sym;
          tvalid      <= 1'b1;
          shift_buf   <= '0;
          bit_count   <= 4'd0;
        end else if (clen == 4'(MAX_CODE)) begin
          shift_buf <= '0;
          bit_count <= 4'd0;
        end else begin
          shift_buf <= cand;
          bit_count <= clen;
        end
      end
    end
  end
endmodule

// File: tb/tb_huffman_shift_reg.sv
// Directed bench for huffman_shift_reg: chunk timing, spanning codewords, invalid codes,
// async reset and an encoded symbol stream.

module tb_huffman_shift_reg;
  logic              clk = 1'b0;
  logic              reset;
  logic              sValid;
  logic [3:0]        in_bits;
  logic [2:0]        in_len;
  logic signed [3:0] decodedData;
  logic              tvalid;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int ev_cyc[$];
  int ev_sym[$];

  huffman_shift_reg #(.MAX_CODE(9)) dut (
    .clk         (clk),
    .reset       (reset),
    .sValid      (sValid),
    .in_bits     (in_bits),
    .in_len      (in_len),
    .decodedData (decodedData),
    .tvalid      (tvalid)
  );

  always #5 clk = ~clk;

  // Logs every tvalid pulse with the index of the edge that produced it.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (tvalid) begin
      ev_cyc.push_back(cyc);
      ev_sym.push_back(int'(decodedData));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_event(input string tag, input int idx, input int exp_cyc, input int exp_sym);
    if (ev_cyc.size() > idx) begin
      check({tag, "_edge"}, ev_cyc[idx], exp_cyc);
      check({tag, "_sym"}, ev_sym[idx], exp_sym);
    end else begin
      check({tag, "_missing"}, ev_cyc.size(), idx + 1);
    end
  endtask

  task automatic clear_events();
    ev_cyc.delete();
    ev_sym.delete();
  endtask

  // Returns the accept edge index; leaves enough idle cycles for the chunk to drain.
  task automatic send(input logic [3:0] b, input logic [2:0] l, input int hold, output int acc);
    @(posedge clk); #2;
    sValid  = 1'b1;
    in_bits = b;
    in_len  = l;
    acc     = cyc + 1;
    repeat (hold) @(posedge clk);
    #2;
    sValid = 1'b0;
    in_len = 3'd0;
    repeat (int'(l) + 2) @(posedge clk);
  endtask

  task automatic encode(input int s, output logic [8:0] code, output int len);
    case (s)
      -8: begin code = 9'b111111100; len = 9; end
      -7: begin code = 9'b011111101; len = 8; end
      -6: begin code = 9'b001111101; len = 7; end
      -5: begin code = 9'b000111101; len = 6; end
      -4: begin code = 9'b000011101; len = 5; end
      -3: begin code = 9'b000001101; len = 4; end
      -2: begin code = 9'b000000101; len = 3; end
      -1: begin code = 9'b000000011; len = 3; end
       0: begin code = 9'b000000000; len = 2; end
       1: begin code = 9'b000000010; len = 3; end
       2: begin code = 9'b000000100; len = 3; end
       3: begin code = 9'b000001100; len = 4; end
       4: begin code = 9'b000011100; len = 5; end
       5: begin code = 9'b000111100; len = 6; end
       6: begin code = 9'b001111100; len = 7; end
      default: begin code = 9'b011111100; len = 8; end
    endcase
  endtask

  initial begin
    int a;
    int syms[17] = '{3, -1, 0, 7, -8, 2, -5, 1, 4, -6, 6, -2, 5, -3, -4, -7, 0};
    logic bitq[$];
    logic [8:0] code;
    int len;
    logic [3:0] b;
    int l;

    reset   = 1'b0;
    sValid  = 1'b0;
    in_bits = 4'd0;
    in_len  = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", int'(tvalid), 0);
    check("rst_data", int'(decodedData), 0);
    check("rst_count", int'(dut.bit_count), 0);
    check("rst_buf", int'(dut.shift_buf), 0);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Two 00 codewords from one chunk; sValid held two cycles loads it once.
    clear_events();
    send(4'b0000, 3'd4, 2, a);
    check("t2_count", ev_cyc.size(), 2);
    check_event("t2_ev0", 0, a + 2, 0);
    check_event("t2_ev1", 1, a + 4, 0);
    check("t2_bitcnt", int'(dut.bit_count), 0);

    // 010 hit, leftover 1, then 1+101 -> 1101.
    clear_events();
    send(4'b0101, 3'd4, 1, a);
    check("t3a_count", ev_cyc.size(), 1);
    check_event("t3a_ev0", 0, a + 3, 1);
    check("t3a_bitcnt", int'(dut.bit_count), 1);
    check("t3a_buf", int'(dut.shift_buf), 1);
    clear_events();
    send(4'b0101, 3'd3, 1, a);
    check("t3b_count", ev_cyc.size(), 1);
    check_event("t3b_ev0", 0, a + 3, -3);
    check("t3b_hold", int'(decodedData), -3);

    // Async reset with leftover bits; the next chunk must decode from an empty buffer.
    clear_events();
    send(4'b0011, 3'd2, 1, a);
    check("t1_pre_count", int'(dut.bit_count), 2);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("t1_tvalid", int'(tvalid), 0);
    check("t1_data", int'(decodedData), 0);
    check("t1_bitcnt", int'(dut.bit_count), 0);
    check("t1_buf", int'(dut.shift_buf), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    clear_events();
    send(4'b0100, 3'd4, 1, a);
    check("t1_post_count", ev_cyc.size(), 1);
    check_event("t1_post_ev0", 0, a + 3, 1);
    check("t1_post_bitcnt", int'(dut.bit_count), 1);

    // Longest code 111111100 spanning three chunks; start from an empty buffer.
    reset = 1'b0;
    #2 reset = 1'b1;
    clear_events();
    send(4'b1111, 3'd4, 1, a);
    send(4'b0111, 3'd3, 1, a);
    check("t4_early", ev_cyc.size(), 0);
    check("t4_bitcnt", int'(dut.bit_count), 7);
    send(4'b0000, 3'd2, 1, a);
    check("t4_count", ev_cyc.size(), 1);
    check_event("t4_ev0", 0, a + 2, -8);

    // Nine ones: invalid, silently cleared; then 0100 decodes 1 with a leftover 0.
    clear_events();
    send(4'b1111, 3'd4, 1, a);
    send(4'b1111, 3'd4, 1, a);
    send(4'b0001, 3'd1, 1, a);
    check("t5_count", ev_cyc.size(), 0);
    check("t5_bitcnt", int'(dut.bit_count), 0);
    check("t5_buf", int'(dut.shift_buf), 0);
    send(4'b0100, 3'd4, 1, a);
    check("t5_post_count", ev_cyc.size(), 1);
    check_event("t5_post_ev0", 0, a + 3, 1);
    check("t5_post_bitcnt", int'(dut.bit_count), 1);

    // Encoded symbol stream split into 4-bit chunks with a short tail.
    reset = 1'b0;
    #2 reset = 1'b1;
    clear_events();
    foreach (syms[i]) begin
      encode(syms[i], code, len);
      for (int k = len - 1; k >= 0; k--) bitq.push_back(code[k]);
    end
    for (int p = 0; p < bitq.size(); p += 4) begin
      l = (bitq.size() - p < 4) ? bitq.size() - p : 4;
      b = 4'd0;
      for (int k = 0; k < l; k++) b[l - 1 - k] = bitq[p + k];
      send(b, 3'(l), 1, a);
    end
    check("t6_count", ev_sym.size(), 17);
    foreach (syms[i]) begin
      if (ev_sym.size() > i) check($sformatf("t6_sym%0d", i), ev_sym[i], syms[i]);
    end
    check("t6_bitcnt", int'(dut.bit_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
